mdu_e: RTL and testbench

- E-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the ID/EX register outputs: forwarded V1/V2 and the MDU op field.
- Performs mult/multu/div/divu with fixed multi-cycle latency, handles mthi/mtlo, and provides HI/LO reads for mfhi/mflo.
- Drives the busy/stall request used by the hazard unit in D.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_calc.sv | 54 +++++
 rtl/mdu_e.sv | 112 +++++++++++
 tb/tb_mdu_e.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encoding,
// HI/LO read-select constants and the start-op classifier.
package mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  function automatic logic is_mdu_start(input logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// A zero divisor is flagged; the quotient/remainder outputs are then don't-care.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] phi,
  output logic [DATA_W-1:0] plo,
  output logic              div0
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [DATA_W-1:0]   b_udiv;
  logic [DATA_W-1:0]   b_sdiv;
  logic [DATA_W-1:0]   q_u;
  logic [DATA_W-1:0]   r_u;
  logic [DATA_W-1:0]   q_s;
  logic [DATA_W-1:0]   r_s;
  logic                b_zero;
  logic                s_ovf;

  assign b_zero = (b == '0);
  assign s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign prod_u = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});

  // Divisors are steered to 1 for zero/overflow so the dividers never see an undefined case.
  assign b_udiv = b_zero ? 32'd1 : b;
  assign b_sdiv = (b_zero || s_ovf) ? 32'd1 : b;

  assign q_u = a / b_udiv;
  assign r_u = a % b_udiv;
  assign q_s = s_ovf ? 32'h8000_0000 : DATA_W'($signed(a) / $signed(b_sdiv));
  assign r_s = s_ovf ? 32'd0         : DATA_W'($signed(a) % $signed(b_sdiv));

  assign div0 = b_zero && ((op == MDU_DIV) || (op == MDU_DIVU));

  always_comb begin
    phi = '0;
    plo = '0;
    case (mdu_op_e'(op))
      MDU_MULT:  {phi, plo} = prod_s;
      MDU_MULTU: {phi, plo} = prod_u;
      MDU_DIV:   begin phi = r_s; plo = q_s; end
      MDU_DIVU:  begin phi = r_u; plo = q_u; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: fixed-latency mult/div into pending registers,
// committed to HI/LO when the busy counter expires; mthi/mtlo and HI/LO reads.
module mdu_e
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [OP_W-1:0]   E_MDUOp,
  input  logic [DATA_W-1:0] E_A,
  input  logic [DATA_W-1:0] E_B,
  input  logic              E_HILO_Sel,
  output logic [DATA_W-1:0] E_MDU_Out,
  output logic              E_MDU_Busy,
  output logic              E_MDU_StallReq,
  output logic [DATA_W-1:0] Q_HI,
  output logic [DATA_W-1:0] Q_LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] phi_q, phi_d;
  logic [DATA_W-1:0] plo_q, plo_d;

  logic [DATA_W-1:0] calc_hi;
  logic [DATA_W-1:0] calc_lo;
  logic              calc_div0;
  logic              idle;
  logic              start;
  logic              is_mul;

  mdu_calc u_calc (
    .op   (E_MDUOp),
    .a    (E_A),
    .b    (E_B),
    .phi  (calc_hi),
    .plo  (calc_lo),
    .div0 (calc_div0)
  );

  assign idle   = (cnt_q == '0);
  assign start  = idle && is_mdu_start(E_MDUOp);
  assign is_mul = (E_MDUOp == MDU_MULT) || (E_MDUOp == MDU_MULTU);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
    end
  end

  // Next-state: counter load on start, countdown while busy.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      cnt_d  = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      busy_d = 1'b1;
    end else if (!idle) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  // Datapath: divide-by-zero parks the current HI/LO so the commit is a no-op.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    if (start) begin
      phi_d = calc_div0 ? hi_q : calc_hi;
      plo_d = calc_div0 ? lo_q : calc_lo;
    end else if (idle) begin
      if (E_MDUOp == MDU_MTHI) hi_d = E_A;
      if (E_MDUOp == MDU_MTLO) lo_d = E_A;
    end else if (cnt_q == CNT_W'(1)) begin
      hi_d = phi_q;
      lo_d = plo_q;
    end
  end

  assign E_MDU_Busy     = busy_q;
  assign E_MDU_StallReq = busy_q || is_mdu_start(E_MDUOp);
  assign E_MDU_Out      = (E_HILO_Sel == HILO_SEL_HI) ? hi_q : lo_q;
  assign Q_HI           = hi_q;
  assign Q_LO           = lo_q;

  // The hazard unit must hold HI/LO-writing ops in D while busy; they are dropped here.
  a_no_op_while_busy : assert property (@(posedge clk) disable iff (RESET)
    !(busy_q && (is_mdu_start(E_MDUOp) || E_MDUOp == MDU_MTHI || E_MDUOp == MDU_MTLO)))
    else $warning("mdu_e: HI/LO op issued while busy was dropped");

endmodule

// File: tb/tb_mdu_e.sv
// Directed bench for mdu_e: vector table run back-to-back plus hand sequences
// for issue-while-busy, mid-operation reset and back-to-back start on the busy fall.
module tb_mdu_e;
  import mdu_pkg::*;

  logic        clk;
  logic        RESET;
  logic [2:0]  E_MDUOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_HILO_Sel;
  logic [31:0] E_MDU_Out;
  logic        E_MDU_Busy;
  logic        E_MDU_StallReq;
  logic [31:0] Q_HI;
  logic [31:0] Q_LO;

  int checks;
  int fails;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk            (clk),
    .RESET          (RESET),
    .E_MDUOp        (E_MDUOp),
    .E_A            (E_A),
    .E_B            (E_B),
    .E_HILO_Sel     (E_HILO_Sel),
    .E_MDU_Out      (E_MDU_Out),
    .E_MDU_Busy     (E_MDU_Busy),
    .E_MDU_StallReq (E_MDU_StallReq),
    .Q_HI           (Q_HI),
    .Q_LO           (Q_LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for busy to drop, returning the number of cycles it was observed high.
  task automatic wait_idle(output int n);
    n = 0;
    while (E_MDU_Busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    chk({tag, " Q_HI"}, Q_HI, hi);
    chk({tag, " Q_LO"}, Q_LO, lo);
    E_HILO_Sel = HILO_SEL_HI;
    #1 chk({tag, " out_hi"}, E_MDU_Out, hi);
    E_HILO_Sel = HILO_SEL_LO;
    #1 chk({tag, " out_lo"}, E_MDU_Out, lo);
  endtask

  initial begin
    int n;
    logic exp_stall;
    checks = 0;
    fails  = 0;

    vecs[0]  = '{3'd1, 32'hFFFF_FFFD, 32'd5,        5,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd6, 32'h1234_5678, 32'd0,        0,  32'hFFFF_FFFF, 32'h1234_5678};
    vecs[4]  = '{3'd4, 32'd7,         32'd0,        10, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[5]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{3'd5, 32'hA5A5_A5A5, 32'd0,        0,  32'hA5A5_A5A5, 32'h8000_0000};
    vecs[7]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{3'd3, 32'd0,         32'd0,        10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 0,  32'h0000_0001, 32'hFFFF_FFFD};
    vecs[11] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};

    // Reset state
    RESET = 1'b1; E_MDUOp = 3'd0; E_A = '0; E_B = '0; E_HILO_Sel = HILO_SEL_LO;
    step(); step();
    chk("rst busy", 32'(E_MDU_Busy), 32'd0);
    chk("rst stall nop", 32'(E_MDU_StallReq), 32'd0);
    check_out("rst", 32'd0, 32'd0);
    E_MDUOp = 3'd1;
    #1 chk("rst stall start", 32'(E_MDU_StallReq), 32'd1);
    E_MDUOp = 3'd0;
    RESET = 1'b0;
    step();

    // Table: each op runs to completion before the next is issued
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      E_MDUOp = vecs[i].op; E_A = vecs[i].a; E_B = vecs[i].b;
      exp_stall = (vecs[i].op >= 3'd1) && (vecs[i].op <= 3'd4);
      #1 chk({tag, " stall"}, 32'(E_MDU_StallReq), 32'(exp_stall));
      chk({tag, " busy0"}, 32'(E_MDU_Busy), 32'd0);
      step();
      E_MDUOp = 3'd0;
      wait_idle(n);
      chk({tag, " cycles"}, 32'(n), 32'(vecs[i].cycles));
      check_out(tag, vecs[i].hi, vecs[i].lo);
    end

    // MTHI issued on busy cycle 3 of a DIVU must be dropped
    E_MDUOp = 3'd4; E_A = 32'd100; E_B = 32'd7;
    step();
    E_MDUOp = 3'd0;
    n = 0;
    while (E_MDU_Busy === 1'b1 && n < 100) begin
      n++;
      if (n == 3) begin
        E_MDUOp = 3'd5; E_A = 32'hDEAD_BEEF;
        #1 chk("mthi busy stall", 32'(E_MDU_StallReq), 32'd1);
      end else begin
        E_MDUOp = 3'd0;
      end
      step();
    end
    E_MDUOp = 3'd0;
    chk("divu cycles", 32'(n), 32'd10);
    check_out("divu", 32'd2, 32'd14);
    step();
    check_out("divu settle", 32'd2, 32'd14);

    // Asynchronous reset mid busy cycle 2 aborts the MULT
    E_MDUOp = 3'd1; E_A = 32'd3; E_B = 32'd4;
    step();
    E_MDUOp = 3'd0;
    step();
    chk("pre-rst busy", 32'(E_MDU_Busy), 32'd1);
    #2 RESET = 1'b1;
    #1 chk("async busy", 32'(E_MDU_Busy), 32'd0);
    chk("async hi", Q_HI, 32'd0);
    chk("async lo", Q_LO, 32'd0);
    RESET = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("post-rst busy", 32'(E_MDU_Busy), 32'd0);
    check_out("post-rst", 32'd0, 32'd0);

    // Back-to-back: DIV started on the cycle the MULT busy falls
    E_MDUOp = 3'd1; E_A = 32'd2; E_B = 32'd3;
    step();
    E_MDUOp = 3'd0;
    wait_idle(n);
    chk("b2b mult cycles", 32'(n), 32'd5);
    chk("b2b fall lo", Q_LO, 32'd6);
    chk("b2b fall hi", Q_HI, 32'd0);
    E_MDUOp = 3'd3; E_A = 32'd6; E_B = 32'd4;
    #1 chk("b2b stall", 32'(E_MDU_StallReq), 32'd1);
    step();
    E_MDUOp = 3'd0;
    chk("b2b div busy", 32'(E_MDU_Busy), 32'd1);
    chk("b2b div lo hold", Q_LO, 32'd6);
    wait_idle(n);
    chk("b2b div cycles", 32'(n), 32'd10);
    check_out("b2b div", 32'd2, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
